muldiv_sequencer: RTL and testbench

Multi-cycle unsigned multiply/divide unit that time-multiplexes a single WIDTH-bit ripple adder/subtractor, one add or subtract per clock.
- Multiply: shift-and-add.
- Divide: restoring division.
- Sits beside the ALU. The core issues a start pulse, stalls on busy, and captures results on done.

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_sequencer_adder.sv | 35 +++
 rtl/muldiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit.
//   - FSM state encoding (IDLE / RUN / FINISH)
//   - operation select encoding for the op input
package muldiv_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic OP_MULU = 1'b0;
    localparam logic OP_DIVU = 1'b1;

endpackage : muldiv_pkg

// File: rtl/muldiv_sequencer_adder.sv
// Parameterised WIDTH-bit ripple-carry adder/subtractor.
// Ports:
//   a, b       operands
//   sub        0: sum = a + b, 1: sum = a - b (two's complement, carry-in = 1)
//   sum        WIDTH-bit result
//   carry_out  carry out of the MSB; for subtraction 1 means "no borrow" (a >= b)
// Only sum and carry_out are provided; the sequencer has no use for
// signed overflow or set-less-than, so those flags are not built here.
module muldiv_sequencer_adder #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_eff;

    // Subtraction is a + ~b + 1: invert b and inject the +1 as carry-in.
    assign carry[0] = sub;
    assign b_eff    = b ^ {WIDTH{sub}};

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi]     = a[gi] ^ b_eff[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b_eff[gi]) | (carry[gi] & (a[gi] ^ b_eff[gi]));
        end
    endgenerate

    assign carry_out = carry[WIDTH];

endmodule : muldiv_sequencer_adder

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply (shift-and-add) / divide (restoring) unit that
// shares one WIDTH-bit ripple adder/subtractor, one add or subtract per clock.
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request, sampled only in IDLE
//   op           0 = MULU, 1 = DIVU
//   A, B         multiplicand/dividend, multiplier/divisor
//   busy         high while iterating (RUN)
//   done         one-cycle pulse, results valid in this cycle
//   result_lo    MULU: product low half;  DIVU: quotient
//   result_hi    MULU: product high half; DIVU: remainder
//   div_by_zero  DIVU with B = 0; cleared on the next accepted start
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_by_zero
);

    logic [1:0]       state_reg;
    logic             op_reg;
    // acc_reg is hi (MULU) / rem (DIVU); shq_reg is lo (MULU) / quo (DIVU);
    // opnd_reg is mcand (MULU) / dvsr (DIVU).
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] shq_reg;
    logic [WIDTH-1:0] opnd_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] result_lo_reg;
    logic [WIDTH-1:0] result_hi_reg;
    logic             dbz_reg;

    logic [WIDTH-1:0] rem_shift;
    logic [WIDTH-1:0] adder_a;
    logic [WIDTH-1:0] adder_sum;
    logic             adder_cout;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] shq_next;
    logic             div_take;

    // Remainder shifted left by one with the next dividend bit brought in.
    // The bit shifted out (acc_reg[WIDTH-1]) is the implicit 17th bit of the
    // partial remainder; if set, the subtraction always succeeds.
    assign rem_shift = {acc_reg[WIDTH-2:0], shq_reg[WIDTH-1]};
    assign adder_a   = (op_reg == OP_DIVU) ? rem_shift : acc_reg;

    muldiv_sequencer_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a         (adder_a),
        .b         (opnd_reg),
        .sub       (op_reg),
        .sum       (adder_sum),
        .carry_out (adder_cout)
    );

    assign div_take = acc_reg[WIDTH-1] | adder_cout;

    always_comb begin
        acc_next = acc_reg;
        shq_next = shq_reg;
        if (op_reg == OP_MULU) begin
            if (shq_reg[0]) begin
                {acc_next, shq_next} = {adder_cout, adder_sum, shq_reg[WIDTH-1:1]};
            end else begin
                {acc_next, shq_next} = {1'b0, acc_reg, shq_reg[WIDTH-1:1]};
            end
        end else begin
            acc_next = div_take ? adder_sum : rem_shift;
            shq_next = {shq_reg[WIDTH-2:0], div_take};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_MULU;
            acc_reg       <= '0;
            shq_reg       <= '0;
            opnd_reg      <= '0;
            cnt_reg       <= '0;
            result_lo_reg <= '0;
            result_hi_reg <= '0;
            dbz_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg  <= op;
                        cnt_reg <= CNT_W'(WIDTH);
                        dbz_reg <= 1'b0;
                        acc_reg <= '0;
                        if (op == OP_MULU) begin
                            shq_reg  <= B;
                            opnd_reg <= A;
                        end else begin
                            shq_reg  <= A;
                            opnd_reg <= B;
                        end
                        if (op == OP_DIVU && B == '0) begin
                            // Skip iterating: results are fixed by definition.
                            state_reg     <= ST_FINISH;
                            dbz_reg       <= 1'b1;
                            result_lo_reg <= '1;
                            result_hi_reg <= A;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc_reg <= acc_next;
                    shq_reg <= shq_next;
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                    // Last iteration: both operations leave hi/rem in acc and
                    // lo/quo in shq, so the result mapping is shared.
                    if (cnt_reg <= CNT_W'(1)) begin
                        state_reg     <= ST_FINISH;
                        result_hi_reg <= acc_next;
                        result_lo_reg <= shq_next;
                    end
                end
                ST_FINISH: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state_reg == ST_RUN);
    assign done        = (state_reg == ST_FINISH);
    assign result_lo   = result_lo_reg;
    assign result_hi   = result_hi_reg;
    assign div_by_zero = dbz_reg;

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer (WIDTH = 16).
// Latency is counted in falling edges after the accepting rising edge; done
// observed at count N means done was high for the core to capture at edge N.
module tb_muldiv_sequencer;

    localparam int WIDTH = 16;
    localparam int TIMEOUT = 40;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    int checks_total  = 0;
    int checks_passed = 0;

    muldiv_sequencer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .A           (a_in),
        .B           (b_in),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue a one-cycle start and wait for done (stimulus only, no checking).
    task automatic run_op(input logic o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output int lat, output logic busy_first);
        @(negedge clk);
        start = 1'b1; op = o; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = '0; b_in = '0;
        lat = 1;
        busy_first = busy;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks_total++;
        if ({busy, done, result_lo, result_hi, div_by_zero} !== '0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b lo=%h hi=%h dbz=%b, want all 0",
                     busy, done, result_lo, result_hi, div_by_zero);
        end else checks_passed++;
        $display("reset: busy=%b done=%b lo=%h hi=%h dbz=%b", busy, done, result_lo, result_hi, div_by_zero);
    endtask

    task automatic test_mulu();
        logic [WIDTH-1:0] va [2] = '{16'd3, 16'hFFFF};
        logic [WIDTH-1:0] vb [2] = '{16'd5, 16'hFFFF};
        logic [WIDTH-1:0] ehi[2] = '{16'h0000, 16'hFFFE};
        logic [WIDTH-1:0] elo[2] = '{16'h000F, 16'h0001};
        int lat;
        logic bf;
        for (int i = 0; i < 2; i++) begin
            run_op(1'b0, va[i], vb[i], lat, bf);
            $display("MULU %h*%h: lat=%0d hi=%h lo=%h busy_first=%b", va[i], vb[i], lat, result_hi, result_lo, bf);
            checks_total++;
            if (lat !== 17 || !done) $display("FAIL mulu_latency[%0d]: got %0d (done=%b), want 17", i, lat, done);
            else checks_passed++;
            checks_total++;
            if ({result_hi, result_lo} !== {ehi[i], elo[i]})
                $display("FAIL mulu_result[%0d]: got %h_%h, want %h_%h", i, result_hi, result_lo, ehi[i], elo[i]);
            else checks_passed++;
            checks_total++;
            if (bf !== 1'b1 || busy !== 1'b0)
                $display("FAIL mulu_busy[%0d]: got first=%b at_done=%b, want 1/0", i, bf, busy);
            else checks_passed++;
        end
    endtask

    task automatic test_divu();
        logic [WIDTH-1:0] va [3] = '{16'd100, 16'hFFFF, 16'h8000};
        logic [WIDTH-1:0] vb [3] = '{16'd7,   16'h0001, 16'hFFFF};
        logic [WIDTH-1:0] eq [3] = '{16'd14,  16'hFFFF, 16'h0000};
        logic [WIDTH-1:0] er [3] = '{16'd2,   16'h0000, 16'h8000};
        int lat;
        logic bf;
        for (int i = 0; i < 3; i++) begin
            run_op(1'b1, va[i], vb[i], lat, bf);
            $display("DIVU %h/%h: lat=%0d quo=%h rem=%h dbz=%b", va[i], vb[i], lat, result_lo, result_hi, div_by_zero);
            checks_total++;
            if (lat !== 17 || !done) $display("FAIL divu_latency[%0d]: got %0d (done=%b), want 17", i, lat, done);
            else checks_passed++;
            checks_total++;
            if ({result_lo, result_hi, div_by_zero} !== {eq[i], er[i], 1'b0})
                $display("FAIL divu_result[%0d]: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=0",
                         i, result_lo, result_hi, div_by_zero, eq[i], er[i]);
            else checks_passed++;
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        logic bf;
        run_op(1'b1, 16'h1234, 16'h0000, lat, bf);
        $display("DIVU 1234/0: lat=%0d quo=%h rem=%h dbz=%b busy=%b", lat, result_lo, result_hi, div_by_zero, busy);
        checks_total++;
        if (lat !== 1 || !done) $display("FAIL dbz_latency: got %0d (done=%b), want 1", lat, done);
        else checks_passed++;
        checks_total++;
        if ({result_lo, result_hi, div_by_zero, busy} !== {16'hFFFF, 16'h1234, 1'b1, 1'b0})
            $display("FAIL dbz_result: got q=%h r=%h dbz=%b busy=%b, want FFFF 1234 1 0",
                     result_lo, result_hi, div_by_zero, busy);
        else checks_passed++;
    endtask

    task automatic test_start_while_busy();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 16'h0100; b_in = 16'h0100;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
            if (lat == 5) begin
                start = 1'b1; op = 1'b1; a_in = 16'd9; b_in = 16'd3;
            end else if (lat == 6) begin
                start = 1'b0;
            end
        end
        $display("MULU 0100*0100 with mid-run start: lat=%0d hi=%h lo=%h", lat, result_hi, result_lo);
        checks_total++;
        if (lat !== 17 || {result_hi, result_lo} !== 32'h0001_0000)
            $display("FAIL start_while_busy: got lat=%0d %h_%h, want lat=17 0001_0000", lat, result_hi, result_lo);
        else checks_passed++;
    endtask

    task automatic test_back_to_back();
        int lat;
        logic bf;
        run_op(1'b1, 16'd1000, 16'd33, lat, bf);
        $display("DIVU 1000/33: lat=%0d quo=%h rem=%h", lat, result_lo, result_hi);
        checks_total++;
        if (lat !== 17 || {result_lo, result_hi} !== {16'd30, 16'd10})
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want 17 001e 000a", lat, result_lo, result_hi);
        else checks_passed++;
        // Now in FINISH: start held high here is ignored, then accepted in IDLE.
        start = 1'b1; op = 1'b0; a_in = 16'h1234; b_in = 16'h0010;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        $display("MULU 1234*0010 back-to-back: lat=%0d hi=%h lo=%h dbz=%b", lat, result_hi, result_lo, div_by_zero);
        checks_total++;
        if (lat !== 17 || {result_hi, result_lo} !== 32'h0001_2340)
            $display("FAIL b2b_second: got lat=%0d %h_%h, want 17 0001_2340", lat, result_hi, result_lo);
        else checks_passed++;
    endtask

    task automatic test_dbz_cleared();
        int lat;
        logic bf;
        run_op(1'b1, 16'h00AA, 16'h0000, lat, bf);
        run_op(1'b0, 16'd2, 16'd3, lat, bf);
        $display("MULU 2*3 after dbz: lat=%0d lo=%h dbz=%b", lat, result_lo, div_by_zero);
        checks_total++;
        if (div_by_zero !== 1'b0 || result_lo !== 16'd6 || result_hi !== 16'd0)
            $display("FAIL dbz_cleared: got dbz=%b hi=%h lo=%h, want 0 0000 0006", div_by_zero, result_hi, result_lo);
        else checks_passed++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        int done_seen;
        @(negedge clk);
        start = 1'b1; op = 1'b0; a_in = 16'h00FF; b_in = 16'h00FF;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (n < 8) begin
            @(negedge clk);
            n++;
        end
        checks_total++;
        if (busy !== 1'b1) $display("FAIL busy_mid_run: got %b, want 1", busy);
        else checks_passed++;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset at RUN cycle 8: busy=%b done=%b lo=%h hi=%h dbz=%b", busy, done, result_lo, result_hi, div_by_zero);
        checks_total++;
        if ({busy, done, result_lo, result_hi, div_by_zero} !== '0)
            $display("FAIL reset_mid_run: got busy=%b done=%b lo=%h hi=%h dbz=%b, want all 0",
                     busy, done, result_lo, result_hi, div_by_zero);
        else checks_passed++;
        done_seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        checks_total++;
        if (done_seen !== 0) $display("FAIL no_done_after_reset: got %0d active cycles, want 0", done_seen);
        else checks_passed++;
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_divu();
        test_div_by_zero();
        test_start_while_busy();
        test_back_to_back();
        test_dbz_cleared();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_muldiv_sequencer
